dmem_port_arbiter: RTL and testbench

// Shares the single data read/write port of the block memory between the CPU

---
 rtl/dmem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the block-memory data port between the CPU LSU
// (single-beat accesses) and the NN accelerator (locked 1..16-word bursts).
//
// Ports:
//   iclk, irst_n            clock, async active-low reset
//   iCpuReq/We/Addr/WData   CPU single access request (held until oCpuGnt)
//   oCpuGnt                 CPU access performed this cycle
//   oCpuRData/oCpuRValid    registered CPU read data, pulse the cycle after
//   iAccReq/We/Addr/Len     accelerator burst request (held until first oAccGnt)
//   iAccWData               write data for the current beat
//   oAccGnt/oAccDone        beat performed / last beat of burst
//   oAccRData/oAccRValid    registered accelerator read data, pulse per beat
//   oMemAddr/Write/Data     to memory; iMemData combinational read data back
module dmem_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 16
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [15:0]       iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWData,
  output logic              oCpuGnt,
  output logic [DATA_W-1:0] oCpuRData,
  output logic              oCpuRValid,
  input  logic              iAccReq,
  input  logic              iAccWe,
  input  logic [15:0]       iAccAddr,
  input  logic [3:0]        iAccLen,
  input  logic [DATA_W-1:0] iAccWData,
  output logic              oAccGnt,
  output logic [DATA_W-1:0] oAccRData,
  output logic              oAccRValid,
  output logic              oAccDone,
  output logic [15:0]       oMemAddr,
  output logic              oMemWrite,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData
);

  localparam int CW = $clog2(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CPU,
    ACC
  } state_t;

  state_t              state_q;
  logic                last_acc_q;
  logic                acc_we_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CW-1:0]       len_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   acc_rdata_q;
  logic                cpu_rvalid_q;
  logic                acc_rvalid_q;

  logic                pick_cpu;
  logic                acc_last;
  logic [ADDR_W-1:0]   acc_addr;
  logic [ADDR_W-1:0]   cpu_addr;

  // Only the low ADDR_W address bits reach memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{iCpuAddr[15:ADDR_W], iAccAddr[15:ADDR_W]};

  // On a tie the requester that did not own the port last wins.
  assign pick_cpu = iCpuReq && (!iAccReq || last_acc_q);
  assign acc_last = (cnt_q == len_q);
  // Burst addresses wrap inside the ADDR_W space.
  assign acc_addr = base_q + ADDR_W'(cnt_q);
  assign cpu_addr = iCpuAddr[ADDR_W-1:0];

  always_comb begin
    oCpuGnt   = 1'b0;
    oAccGnt   = 1'b0;
    oAccDone  = 1'b0;
    oMemAddr  = '0;
    oMemWrite = 1'b0;
    oMemData  = '0;
    unique case (state_q)
      CPU: begin
        oCpuGnt   = 1'b1;
        oMemAddr  = 16'(cpu_addr);
        oMemWrite = iCpuWe;
        oMemData  = iCpuWData;
      end
      ACC: begin
        oAccGnt   = 1'b1;
        oAccDone  = acc_last;
        oMemAddr  = 16'(acc_addr);
        oMemWrite = acc_we_q;
        oMemData  = iAccWData;
      end
      default: ;
    endcase
  end

  assign oCpuRData  = cpu_rdata_q;
  assign oCpuRValid = cpu_rvalid_q;
  assign oAccRData  = acc_rdata_q;
  assign oAccRValid = acc_rvalid_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= IDLE;
      last_acc_q   <= 1'b1;
      acc_we_q     <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      acc_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      acc_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      acc_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_cpu) begin
            state_q <= CPU;
          end else if (iAccReq) begin
            state_q  <= ACC;
            base_q   <= iAccAddr[ADDR_W-1:0];
            acc_we_q <= iAccWe;
            len_q    <= iAccLen[CW-1:0];
            cnt_q    <= '0;
          end
        end
        CPU: begin
          if (!iCpuWe) begin
            cpu_rdata_q  <= iMemData;
            cpu_rvalid_q <= 1'b1;
          end
          last_acc_q <= 1'b0;
          state_q    <= IDLE;
        end
        ACC: begin
          if (!acc_we_q) begin
            acc_rdata_q  <= iMemData;
            acc_rvalid_q <= 1'b1;
          end
          cnt_q <= cnt_q + CW'(1);
          if (acc_last) begin
            cnt_q      <= '0;
            last_acc_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench with a write/read-data scoreboard
// and a small memory model behind the arbiter.
module tb_dmem_port_arbiter;

  logic        iclk = 1'b0;
  logic        irst_n = 1'b0;
  logic        iCpuReq, iCpuWe;
  logic [15:0] iCpuAddr, iCpuWData;
  logic        oCpuGnt, oCpuRValid;
  logic [15:0] oCpuRData;
  logic        iAccReq, iAccWe;
  logic [15:0] iAccAddr, iAccWData;
  logic [3:0]  iAccLen;
  logic        oAccGnt, oAccRValid, oAccDone;
  logic [15:0] oAccRData;
  logic [15:0] oMemAddr, oMemData, iMemData;
  logic        oMemWrite;

  logic [15:0] mem [0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_q  [$];
  logic [15:0] crd_q [$];
  logic [15:0] ard_q [$];

  always #5 iclk = ~iclk;

  dmem_port_arbiter dut (
    .iclk       (iclk),
    .irst_n     (irst_n),
    .iCpuReq    (iCpuReq),
    .iCpuWe     (iCpuWe),
    .iCpuAddr   (iCpuAddr),
    .iCpuWData  (iCpuWData),
    .oCpuGnt    (oCpuGnt),
    .oCpuRData  (oCpuRData),
    .oCpuRValid (oCpuRValid),
    .iAccReq    (iAccReq),
    .iAccWe     (iAccWe),
    .iAccAddr   (iAccAddr),
    .iAccLen    (iAccLen),
    .iAccWData  (iAccWData),
    .oAccGnt    (oAccGnt),
    .oAccRData  (oAccRData),
    .oAccRValid (oAccRValid),
    .oAccDone   (oAccDone),
    .oMemAddr   (oMemAddr),
    .oMemWrite  (oMemWrite),
    .oMemData   (oMemData),
    .iMemData   (iMemData)
  );

  assign iMemData = mem[oMemAddr[10:0]];

  always @(posedge iclk)
    if (oMemWrite) mem[oMemAddr[10:0]] <= oMemData;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  always @(negedge iclk) begin
    if (irst_n) begin
      if (oMemWrite) begin
        chk("wr_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0)
          chk("wr_addr_data", {oMemAddr, oMemData}, wr_q.pop_front());
      end
      if (oCpuRValid) begin
        chk("cpu_rd_expected", 32'(crd_q.size() > 0), 1);
        if (crd_q.size() > 0)
          chk("cpu_rd_data", 32'(oCpuRData), 32'(crd_q.pop_front()));
      end
      if (oAccRValid) begin
        chk("acc_rd_expected", 32'(ard_q.size() > 0), 1);
        if (ard_q.size() > 0)
          chk("acc_rd_data", 32'(oAccRData), 32'(ard_q.pop_front()));
      end
    end
  end

  initial begin
    logic [10:0] a;
    int waited;
    iCpuReq = 0; iCpuWe = 0; iCpuAddr = 0; iCpuWData = 0;
    iAccReq = 0; iAccWe = 0; iAccAddr = 0; iAccLen = 0; iAccWData = 0;

    // reset state
    #12;
    chk("rst_cpu_gnt", 32'(oCpuGnt), 0);
    chk("rst_acc_gnt", 32'(oAccGnt), 0);
    chk("rst_mem_addr", 32'(oMemAddr), 0);
    chk("rst_cpu_rv", 32'(oCpuRValid), 0);
    @(negedge iclk);
    irst_n = 1;
    tick();

    // CPU write 0x00A5 @0x010
    iCpuReq = 1; iCpuWe = 1; iCpuAddr = 16'h0010; iCpuWData = 16'h00A5;
    wr_q.push_back({16'h0010, 16'h00A5});
    chk("cpu_no_gnt_same_cycle", 32'(oCpuGnt), 0);
    tick();
    chk("cpu_wr_gnt", 32'(oCpuGnt), 1);
    chk("cpu_wr_addr", 32'(oMemAddr), 32'h0010);
    chk("cpu_wr_we", 32'(oMemWrite), 1);
    iCpuReq = 0;
    tick();
    chk("cpu_gnt_drop", 32'(oCpuGnt), 0);

    // CPU read @0x010 with upper address bits set
    iCpuReq = 1; iCpuWe = 0; iCpuAddr = 16'hF810;
    crd_q.push_back(16'h00A5);
    tick();
    chk("cpu_rd_gnt", 32'(oCpuGnt), 1);
    chk("cpu_rd_addr_mask", 32'(oMemAddr), 32'h0010);
    chk("cpu_rd_we", 32'(oMemWrite), 0);
    chk("cpu_rv_early", 32'(oCpuRValid), 0);
    iCpuReq = 0;
    tick();
    chk("cpu_rvalid", 32'(oCpuRValid), 1);
    chk("cpu_rdata", 32'(oCpuRData), 32'h00A5);
    tick();
    chk("cpu_rv_pulse", 32'(oCpuRValid), 0);
    chk("cpu_rdata_hold", 32'(oCpuRData), 32'h00A5);

    // accelerator write burst with address wrap
    iAccReq = 1; iAccWe = 1; iAccAddr = 16'h07FE; iAccLen = 4'd3;
    for (int k = 0; k < 4; k++) begin
      a = 11'h7FE + 11'(k);
      wr_q.push_back({5'b0, a, 16'(k + 1)});
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      a = 11'h7FE + 11'(k);
      iAccWData = 16'(k + 1);
      if (k == 0) iAccReq = 0;
      chk("wrap_gnt", 32'(oAccGnt), 1);
      chk("wrap_addr", 32'(oMemAddr), 32'({5'b0, a}));
      chk("wrap_done", 32'(oAccDone), 32'(k == 3));
      tick();
    end
    chk("wrap_idle_gnt", 32'(oAccGnt), 0);

    // tie from reset: CPU first, then ACC
    @(negedge iclk); irst_n = 0;
    @(negedge iclk); irst_n = 1;
    tick();
    iCpuReq = 1; iCpuWe = 1; iCpuAddr = 16'h0020; iCpuWData = 16'h1111;
    iAccReq = 1; iAccWe = 1; iAccAddr = 16'h0100; iAccLen = 0;
    wr_q.push_back({16'h0020, 16'h1111});
    wr_q.push_back({16'h0100, 16'h2222});
    tick();
    chk("tie1_cpu", 32'(oCpuGnt), 1);
    chk("tie1_acc_wait", 32'(oAccGnt), 0);
    iCpuReq = 0;
    tick();
    chk("tie1_idle", 32'(oAccGnt), 0);
    tick();
    iAccWData = 16'h2222;
    chk("tie1_acc", 32'(oAccGnt), 1);
    chk("tie1_done", 32'(oAccDone), 1);
    iAccReq = 0;
    tick();

    // repeat tie: CPU wins again
    iCpuReq = 1; iCpuAddr = 16'h0021; iCpuWData = 16'h3333;
    iAccReq = 1; iAccAddr = 16'h0101;
    wr_q.push_back({16'h0021, 16'h3333});
    wr_q.push_back({16'h0101, 16'h4444});
    tick();
    chk("tie2_cpu", 32'(oCpuGnt), 1);
    chk("tie2_acc_wait", 32'(oAccGnt), 0);
    iCpuReq = 0;
    tick();
    tick();
    iAccWData = 16'h4444;
    chk("tie2_acc", 32'(oAccGnt), 1);
    iAccReq = 0;
    tick();

    // CPU owned last: tie goes to ACC
    iCpuReq = 1; iCpuAddr = 16'h0022; iCpuWData = 16'h5555;
    wr_q.push_back({16'h0022, 16'h5555});
    tick();
    chk("solo_cpu", 32'(oCpuGnt), 1);
    iCpuReq = 0;
    tick();
    iCpuReq = 1; iCpuAddr = 16'h0023; iCpuWData = 16'h6666;
    iAccReq = 1; iAccAddr = 16'h0102;
    wr_q.push_back({16'h0102, 16'h7777});
    wr_q.push_back({16'h0023, 16'h6666});
    tick();
    iAccWData = 16'h7777;
    chk("tie3_acc", 32'(oAccGnt), 1);
    chk("tie3_cpu_wait", 32'(oCpuGnt), 0);
    iAccReq = 0;
    tick();
    chk("tie3_idle", 32'(oCpuGnt), 0);
    tick();
    chk("tie3_cpu", 32'(oCpuGnt), 1);
    iCpuReq = 0;
    tick();

    // 16-beat burst, CPU request arrives mid-burst
    iAccReq = 1; iAccWe = 1; iAccAddr = 16'h0200; iAccLen = 4'd15;
    for (int k = 0; k < 16; k++)
      wr_q.push_back({16'h0200 + 16'(k), 16'h5000 + 16'(k)});
    tick();
    for (int k = 0; k < 16; k++) begin
      iAccWData = 16'h5000 + 16'(k);
      if (k == 0) iAccReq = 0;
      if (k == 2) begin
        iCpuReq = 1; iCpuWe = 1; iCpuAddr = 16'h0300; iCpuWData = 16'hBEEF;
        wr_q.push_back({16'h0300, 16'hBEEF});
      end
      chk("b16_acc_gnt", 32'(oAccGnt), 1);
      chk("b16_cpu_locked", 32'(oCpuGnt), 0);
      chk("b16_done", 32'(oAccDone), 32'(k == 15));
      tick();
    end
    waited = 1;
    while (!oCpuGnt && waited < 40) begin
      tick();
      waited++;
    end
    chk("cpu_after_done", 32'(waited), 2);
    iCpuReq = 0;
    tick();

    // accelerator single-beat read
    iAccReq = 1; iAccWe = 0; iAccAddr = 16'h07FE; iAccLen = 0;
    ard_q.push_back(16'h0001);
    tick();
    chk("rd1_gnt", 32'(oAccGnt), 1);
    chk("rd1_done", 32'(oAccDone), 1);
    chk("rd1_we", 32'(oMemWrite), 0);
    chk("rd1_rv_early", 32'(oAccRValid), 0);
    iAccReq = 0;
    tick();
    chk("rd1_rvalid", 32'(oAccRValid), 1);
    chk("rd1_rdata", 32'(oAccRData), 32'h0001);
    chk("rd1_gnt_off", 32'(oAccGnt), 0);

    // reset during beat 5 of a 16-beat burst
    iAccReq = 1; iAccWe = 1; iAccAddr = 16'h0400; iAccLen = 4'd15;
    for (int k = 0; k < 4; k++)
      wr_q.push_back({16'h0400 + 16'(k), 16'h6000 + 16'(k)});
    tick();
    for (int k = 0; k < 4; k++) begin
      iAccWData = 16'h6000 + 16'(k);
      if (k == 0) iAccReq = 0;
      tick();
    end
    iAccWData = 16'h6004;
    chk("mid_gnt", 32'(oAccGnt), 1);
    irst_n = 0;
    #1;
    chk("mid_rst_gnt", 32'(oAccGnt), 0);
    chk("mid_rst_addr", 32'(oMemAddr), 0);
    chk("mid_rst_we", 32'(oMemWrite), 0);
    chk("mid_rst_done", 32'(oAccDone), 0);
    chk("mid_rst_data", 32'(oMemData), 0);
    chk("mid_rst_acc_rdata", 32'(oAccRData), 0);
    @(negedge iclk);
    irst_n = 1;
    tick();
    chk("post_rst_gnt", 32'(oAccGnt), 0);
    chk("post_rst_done", 32'(oAccDone), 0);
    tick();
    chk("post_rst_idle", 32'(oAccGnt | oCpuGnt), 0);

    // last-owner reset: CPU wins tie again
    iCpuReq = 1; iCpuWe = 1; iCpuAddr = 16'h0024; iCpuWData = 16'h8888;
    iAccReq = 1; iAccWe = 1; iAccAddr = 16'h0103; iAccLen = 0;
    wr_q.push_back({16'h0024, 16'h8888});
    wr_q.push_back({16'h0103, 16'h9999});
    tick();
    chk("tie4_cpu", 32'(oCpuGnt), 1);
    iCpuReq = 0;
    tick();
    tick();
    iAccWData = 16'h9999;
    chk("tie4_acc", 32'(oAccGnt), 1);
    iAccReq = 0;
    tick();
    tick();

    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("crd_q_drained", 32'(crd_q.size()), 0);
    chk("ard_q_drained", 32'(ard_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
